// File: rtl/pe_wdb.sv
// Weight-stationary systolic PE with a double-buffered weight (shadow chain plus active register).
// Optional PE_WDB_SAT_EN: saturating partial-sum adder and a sticky ovf output.
module pe_wdb #(
    parameter int DATA_IN_BW     = 8,
    parameter int WEIGHT_BW      = 8,
    parameter int PARTIAL_SUM_BW = 19
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_IN_BW-1:0]     din,
    input  logic                      din_valid,
    input  logic [PARTIAL_SUM_BW-1:0] psum_in,
    output logic [DATA_IN_BW-1:0]     df_col,
    output logic                      df_col_valid,
    output logic [PARTIAL_SUM_BW-1:0] psum_out,
    output logic                      psum_out_valid,
    input  logic [WEIGHT_BW-1:0]      w_in,
    input  logic                      w_load,
    output logic [WEIGHT_BW-1:0]      w_out,
    input  logic                      w_swap_in,
    output logic                      w_swap_out
`ifdef PE_WDB_SAT_EN
    ,
    output logic                      ovf
`endif
);

    localparam int PROD_BW = DATA_IN_BW + WEIGHT_BW;

    logic [DATA_IN_BW-1:0]            df_col_q, df_col_d;
    logic                             df_col_valid_q, df_col_valid_d;
    logic [PARTIAL_SUM_BW-1:0]        psum_out_q, psum_out_d;
    logic                             psum_out_valid_q, psum_out_valid_d;
    logic [WEIGHT_BW-1:0]             shadow_q, shadow_d;
    logic [WEIGHT_BW-1:0]             active_q, active_d;
    logic                             w_swap_out_q, w_swap_out_d;
    logic signed [PROD_BW-1:0]        din_ext_s, w_ext_s, wx_s;
    logic signed [PARTIAL_SUM_BW-1:0] wx_ext_s;
    logic [PARTIAL_SUM_BW-1:0]        sum_s;
`ifdef PE_WDB_SAT_EN
    logic [PARTIAL_SUM_BW:0]          sum_wide_s;
    logic                             clamp_s;
    logic                             ovf_q, ovf_d;
`endif

    // Next-state logic: MAC with the pre-edge active weight, valid-gated datapath, weight buffering.
    always_comb begin
        din_ext_s = PROD_BW'($signed(din));
        w_ext_s   = PROD_BW'($signed(active_q));
        wx_s      = din_ext_s * w_ext_s;
        wx_ext_s  = PARTIAL_SUM_BW'(wx_s);
`ifdef PE_WDB_SAT_EN
        // One guard bit exposes overflow; the two top bits disagree exactly when the sum left range.
        sum_wide_s = {psum_in[PARTIAL_SUM_BW-1], psum_in} + {wx_ext_s[PARTIAL_SUM_BW-1], wx_ext_s};
        clamp_s    = sum_wide_s[PARTIAL_SUM_BW] ^ sum_wide_s[PARTIAL_SUM_BW-1];
        if (!clamp_s) begin
            sum_s = sum_wide_s[PARTIAL_SUM_BW-1:0];
        end else if (sum_wide_s[PARTIAL_SUM_BW] == 1'b0) begin
            sum_s = {1'b0, {(PARTIAL_SUM_BW-1){1'b1}}};
        end else begin
            sum_s = {1'b1, {(PARTIAL_SUM_BW-1){1'b0}}};
        end
        ovf_d = ovf_q | (din_valid & clamp_s);
`else
        sum_s = psum_in + wx_ext_s;
`endif

        if (din_valid) begin
            df_col_d         = din;
            psum_out_d       = sum_s;
            df_col_valid_d   = 1'b1;
            psum_out_valid_d = 1'b1;
        end else begin
            df_col_d         = df_col_q;
            psum_out_d       = psum_out_q;
            df_col_valid_d   = 1'b0;
            psum_out_valid_d = 1'b0;
        end

        if (w_swap_in) begin
            active_d = shadow_q;
        end else begin
            active_d = active_q;
        end

        if (w_load) begin
            shadow_d = w_in;
        end else begin
            shadow_d = shadow_q;
        end

        w_swap_out_d = w_swap_in;
    end

    // State registers with synchronous reset that drops all in-flight data and both weights.
    always_ff @(posedge clk) begin
        if (rst) begin
            df_col_q         <= {DATA_IN_BW{1'b0}};
            df_col_valid_q   <= 1'b0;
            psum_out_q       <= {PARTIAL_SUM_BW{1'b0}};
            psum_out_valid_q <= 1'b0;
            shadow_q         <= {WEIGHT_BW{1'b0}};
            active_q         <= {WEIGHT_BW{1'b0}};
            w_swap_out_q     <= 1'b0;
`ifdef PE_WDB_SAT_EN
            ovf_q            <= 1'b0;
`endif
        end else begin
            df_col_q         <= df_col_d;
            df_col_valid_q   <= df_col_valid_d;
            psum_out_q       <= psum_out_d;
            psum_out_valid_q <= psum_out_valid_d;
            shadow_q         <= shadow_d;
            active_q         <= active_d;
            w_swap_out_q     <= w_swap_out_d;
`ifdef PE_WDB_SAT_EN
            ovf_q            <= ovf_d;
`endif
        end
    end

    assign df_col         = df_col_q;
    assign df_col_valid   = df_col_valid_q;
    assign psum_out       = psum_out_q;
    assign psum_out_valid = psum_out_valid_q;
    assign w_out          = shadow_q;
    assign w_swap_out     = w_swap_out_q;
`ifdef PE_WDB_SAT_EN
    assign ovf            = ovf_q;
`endif

endmodule
